// File: rtl/grid_memory_responder.sv
// Word-addressed memory responder with a valid/ready request channel, a fixed
// one-cycle read response, and a bulk-clear engine that sweeps CLEAR_VALUE into every word.
module grid_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clear_start,
  output logic                  clear_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    xfer;
  logic                    rd_xfer;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_CLEAR: begin
        // clear_start is deliberately ignored here: the sweep is never restarted
        if (clr_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = !clear_start;
        if (clear_start) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign xfer    = req_valid && req_ready;
  assign rd_xfer = xfer && !req_we;

  // Control and response stage: registered one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      clear_busy <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      clear_busy <= (state_nxt == ST_CLEAR);
      rsp_valid  <= rd_xfer;
      // Counter wraps to 0 on the last word, so the next sweep starts at address 0
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (rd_xfer) rsp_rdata <= mem[req_addr];
    end
  end

  // Storage stage: not reset; the clear sweep owns the write port while active
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (xfer && req_we) begin
      mem[req_addr] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_grid_memory_responder.sv
// Bench for grid_memory_responder (ADDR_WIDTH=4): vector table, directed
// clear/reset sequences and randomized traffic against a behavioural model.
module tb_grid_memory_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_addr;
  logic       req_we;
  logic       req_wdata;
  logic       rsp_valid;
  logic       rsp_rdata;
  logic       clear_start;
  logic       clear_busy;

  grid_memory_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(1), .CLEAR_VALUE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: memory image, remaining clear cycles, last response
  logic m_mem [16];
  int   m_left;
  logic m_rv, m_rd;

  // DUT values sampled by the last step
  logic s_ready, s_rv, s_rd, s_busy;

  typedef struct {
    logic       v;
    logic       we;
    logic [3:0] a;
    logic       wd;
    logic       cs;
    logic       e_ready;
    logic       e_rv;
    logic       e_rd;
    logic       e_busy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 16;
    m_rv = 1'b0;
    m_rd = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 1'b0;
  endtask

  // One clock cycle: called just after a rising edge, returns just after the next one
  task automatic step(input logic v, input logic we, input logic [3:0] a,
                      input logic wd, input logic cs);
    logic exp_ready;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; clear_start = cs;
    exp_ready = (m_left == 0) && !cs;
    @(negedge clk);
    s_ready = req_ready;
    chk("req_ready", req_ready, exp_ready);
    m_rv = 1'b0;
    if (m_left > 0) begin
      m_left--;
    end else if (cs) begin
      m_left = 16;
      for (int i = 0; i < 16; i++) m_mem[i] = 1'b0;
    end else if (v) begin
      if (we) m_mem[a] = wd;
      else begin
        m_rv = 1'b1;
        m_rd = m_mem[a];
      end
    end
    @(posedge clk); #1;
    s_rv = rsp_valid; s_rd = rsp_rdata; s_busy = clear_busy;
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_rdata", rsp_rdata, m_rd);
    chk("clear_busy", clear_busy, m_left > 0);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Counts cycles with clear_busy high, starting just after a release/edge
  task automatic count_busy(output int n);
    n = 0;
    while (clear_busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    logic exp_rd;

    //                v   we  addr  wd  cs  rdy rv  rd  busy
    tbl[0] = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = 1'b0; clear_start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", req_ready, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_rdata", rsp_rdata, 1'b0);
    chk("reset clear_busy", clear_busy, 1'b1);

    // Power-up sweep lasts exactly 16 cycles
    rst_n = 1'b1;
    count_busy(n);
    chk("initial clear cycles", n, 16);
    m_left = 0;

    step(1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
    chk("read 0x7 after clear valid", s_rv, 1'b1);
    chk("read 0x7 after clear data", s_rd, 1'b0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].cs);
      chk($sformatf("vec%0d ready", i), s_ready, tbl[i].e_ready);
      chk($sformatf("vec%0d rsp_valid", i), s_rv, tbl[i].e_rv);
      chk($sformatf("vec%0d rsp_rdata", i), s_rd, tbl[i].e_rd);
      chk($sformatf("vec%0d busy", i), s_busy, tbl[i].e_busy);
    end

    // Fill, then clear with a read held across the whole sweep
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'(i), 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("clear_start blocks ready", s_ready, 1'b0);
    n = 0;
    while (!s_ready && n < 40) begin
      step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      n++;
    end
    chk("held read accepted after cycles", n, 17);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
      chk("post-clear read is zero", s_rd, 1'b0);
    end

    // clear_start held high: sweep not extended, then a fresh clear
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    n = 0;
    while (s_busy && n < 40) begin
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      n++;
    end
    chk("held clear_start sweep steps", n, 16);
    chk("idle between sweeps ready", s_ready, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("second sweep starts", s_busy, 1'b1);
    for (int i = 0; i < 16; i++) idle_step();

    // Reset in the middle of a sweep
    step(1'b1, 1'b1, 4'h5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    chk("read 0x5 before reset", s_rd, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) idle_step();
    rst_n = 1'b0;
    #2;
    chk("async reset rsp_rdata", rsp_rdata, 1'b0);
    chk("async reset rsp_valid", rsp_valid, 1'b0);
    chk("async reset clear_busy", clear_busy, 1'b1);
    chk("async reset req_ready", req_ready, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(n);
    chk("clear cycles after mid-sweep reset", n, 16);
    m_left = 0;
    step(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    chk("read 0x5 after reset clear", s_rd, 1'b0);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 1'($urandom),
           1'($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < 20; i++) idle_step();
    for (int i = 0; i < 16; i++) begin
      exp_rd = m_mem[i];
      step(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
      chk("final sweep read", s_rd, exp_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
